// File: rtl/fsmc_initiator.sv
// FSMC bus master: one 16-bit read or write per accepted command, with setup/strobe/hold timing set in clock cycles.
// Latency: bus_ncs falls on the accept edge; done pulses ADDSET+DATAST cycles later; idle again after ADDSET+DATAST+HOLD cycles.
// Backpressure: cmd_ready is high only in IDLE; commands are ignored while busy, and a held cmd_valid is taken once at the first idle edge.
module fsmc_initiator #(
  parameter int ADDR_W = 2,
  parameter int ADDSET = 2,
  parameter int DATAST = 6,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_wdata,
  output logic              done,
  output logic [15:0]       rdata,
  output logic              bus_ncs,
  output logic              bus_noe,
  output logic              bus_nwe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_dout,
  output logic              bus_oe,
  input  logic [15:0]       bus_din
);

  // Each phase length must fit the 4-bit down-counter and be at least one cycle.
  if (ADDSET < 1 || ADDSET > 15) begin : g_bad_addset
    $error("fsmc_initiator: ADDSET=%0d outside 1..15", ADDSET);
  end
  if (DATAST < 1 || DATAST > 15) begin : g_bad_datast
    $error("fsmc_initiator: DATAST=%0d outside 1..15", DATAST);
  end
  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("fsmc_initiator: HOLD=%0d outside 1..15", HOLD);
  end

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] ADDSET_M1 = 4'(ADDSET - 1);
  localparam logic [3:0] DATAST_M1 = 4'(DATAST - 1);
  localparam logic [3:0] HOLD_M1   = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                done_q, done_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                bus_ncs_q, bus_ncs_d;
  logic                bus_noe_q, bus_noe_d;
  logic                bus_nwe_q, bus_nwe_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [15:0]         bus_dout_q, bus_dout_d;
  logic                bus_oe_q, bus_oe_d;

  logic                accept;
  logic                cnt_last;

  // Handshake uses the registered ready so the accept decision never depends on this cycle's outputs.
  assign accept   = cmd_valid & cmd_ready_q;
  assign cnt_last = (cnt_q == 4'd0);

  // State register, phase counter and all output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 16'h0000;
      bus_ncs_q   <= 1'b1;
      bus_noe_q   <= 1'b1;
      bus_nwe_q   <= 1'b1;
      bus_addr_q  <= '0;
      bus_dout_q  <= 16'h0000;
      bus_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      bus_ncs_q   <= bus_ncs_d;
      bus_noe_q   <= bus_noe_d;
      bus_nwe_q   <= bus_nwe_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_oe_q    <= bus_oe_d;
    end
  end

  // Next state: advance when the phase counter expires, reloading it with the next phase length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = ADDSET_M1;
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          state_d = S_ACCESS;
          cnt_d   = DATAST_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (cnt_last) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs: next value of every pin flop, changed only on phase boundaries so pins are glitch-free and registered.
  always_comb begin
    we_d        = we_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    bus_ncs_d   = bus_ncs_q;
    bus_noe_d   = bus_noe_q;
    bus_nwe_d   = bus_nwe_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    bus_oe_d    = bus_oe_q;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          we_d        = cmd_we;
          bus_ncs_d   = 1'b0;
          bus_addr_d  = cmd_addr;
          bus_oe_d    = cmd_we;
          // Reads leave the previous write data on bus_dout; it is not driven anyway.
          if (cmd_we) begin
            bus_dout_d = cmd_wdata;
          end
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          bus_noe_d = we_q;
          bus_nwe_d = ~we_q;
        end
      end
      S_ACCESS: begin
        if (cnt_last) begin
          bus_noe_d = 1'b1;
          bus_nwe_d = 1'b1;
          done_d    = 1'b1;
          // No synchronizer: DATAST is sized so the responder's data has settled by this edge.
          if (!we_q) begin
            rdata_d = bus_din;
          end
        end
      end
      S_HOLD: begin
        if (cnt_last) begin
          bus_ncs_d   = 1'b1;
          bus_oe_d    = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
        bus_ncs_d   = 1'b1;
        bus_noe_d   = 1'b1;
        bus_nwe_d   = 1'b1;
        bus_oe_d    = 1'b0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign bus_ncs   = bus_ncs_q;
  assign bus_noe   = bus_noe_q;
  assign bus_nwe   = bus_nwe_q;
  assign bus_addr  = bus_addr_q;
  assign bus_dout  = bus_dout_q;
  assign bus_oe    = bus_oe_q;

  // Bus protocol invariants.
  a_no_dual_strobe : assert property (@(posedge clk) disable iff (rst) !(!bus_noe_q && !bus_nwe_q));
  a_strobe_in_cs   : assert property (@(posedge clk) disable iff (rst) (!bus_noe_q || !bus_nwe_q) |-> !bus_ncs_q);
  a_oe_write_only  : assert property (@(posedge clk) disable iff (rst) bus_oe_q |-> (!bus_ncs_q && bus_noe_q && we_q));
  a_done_in_hold   : assert property (@(posedge clk) disable iff (rst) done_q |-> (state_q == S_HOLD));

endmodule

// File: doc/fsmc_initiator.md
Name: fsmc_initiator

Overview:
- Bus master for the asynchronous SRAM-style FSMC interface: ncs, noe, nwe, addr and a 16-bit data bus.
- Lets an FPGA-side controller issue single 16-bit reads and writes to an FSMC-style responder, such as another board's FPGA register/FIFO port, or a loopback bench against our existing responder.
- Accepts one command at a time over a valid/ready handshake and generates setup/strobe/hold timing from clock-cycle parameters.
- Returns read data with a one-cycle done pulse. Tristating of the data pins is done in the top level.

Parameters:
- ADDR_W, 2: bus address width.
- ADDSET, 2: address setup cycles (ncs low, strobes high) before the strobe; range 1..15.
- DATAST, 6: strobe-low cycles; range 1..15. The default covers responders with 4-cycle synchronizer latency from noe-low to driven data.
- HOLD, 1: cycles after the strobe rises before ncs rises; range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready at a clk edge
- cmd_we  in  1  1=write, 0=read; sampled on accept
- cmd_addr  in  ADDR_W  bus address; sampled on accept
- cmd_wdata  in  16  write data; sampled on accept
- done  out  1  one-cycle pulse at end of strobe phase, for both reads and writes
- rdata  out  16  read data; valid from the done cycle until the next read's done
- bus_ncs  out  1  chip select, active-low
- bus_noe  out  1  output enable, active-low
- bus_nwe  out  1  write enable, active-low
- bus_addr  out  ADDR_W  bus address
- bus_dout  out  16  data to drive onto the bus
- bus_oe  out  1  1=top level drives bus_dout onto the data pins
- bus_din  in  16  data pins as seen from the pads

Behaviour:
- All outputs come from flops. There is no combinational path from inputs to bus pins.
- Reset values: cmd_ready=0 while rst is high, 1 from the first cycle after rst falls. bus_ncs=1, bus_noe=1, bus_nwe=1, bus_oe=0, bus_addr=0, bus_dout=0, done=0, rdata=0. State=IDLE.
- States: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE. A 4-bit down-counter is loaded on each state entry.
- IDLE:
  - cmd_ready=1 and bus_ncs=1.
  - On accept, latch we/addr/wdata and enter SETUP. cmd_ready drops on the same edge.
- SETUP, ADDSET cycles:
  - bus_ncs=0 and bus_addr=latched addr; noe=nwe=1.
  - Write: bus_oe=1 and bus_dout=wdata. Read: bus_oe=0.
- ACCESS, DATAST cycles:
  - Read: bus_noe=0. Write: bus_nwe=0.
  - ncs, addr, dout and oe are held from SETUP.
- At the final ACCESS edge:
  - Read: rdata<=bus_din, sampled directly with no synchronizer; DATAST must cover responder latency.
  - The strobe returns high, state goes to HOLD, and done=1 for exactly the first HOLD cycle.
- HOLD, HOLD cycles:
  - Strobes high; ncs, addr, dout and oe are held.
  - At exit, bus_ncs=1 and bus_oe=0. bus_addr and bus_dout keep their last values.
- bus_ncs is low for exactly ADDSET+DATAST+HOLD cycles per transaction.
- At least 1 IDLE cycle with ncs high separates consecutive transactions. Back-to-back period is ADDSET+DATAST+HOLD+1 cycles.
- noe and nwe are never low simultaneously. Neither strobe is low while ncs is high.
- bus_oe is never 1 during a read or in IDLE.
- Commands presented while cmd_ready=0 are ignored. cmd_valid held high through a busy period is accepted once, at the first IDLE edge.
- rst mid-transaction: the next edge forces the reset values listed above. A partial read does not update rdata. No done pulse.
- Parameters outside 1..15 are a configuration error; the implementation must flag them with an elaboration-time check.

Test Plan:
- Read, defaults, accept at edge 0, addr=2'b01, bus_din=16'hA5C3 during ACCESS:
  - -> ncs low cycles 1-9; noe low cycles 3-8; done=1 in cycle 9 with rdata=16'hA5C3; cmd_ready=1 at cycle 10; bus_oe=0 throughout.
- Write, defaults, addr=2'b10, wdata=16'h1234:
  - -> bus_oe=1 and bus_dout=16'h1234 cycles 1-9; nwe low cycles 3-8; noe stays 1; done in cycle 9; ncs high cycle 10.
- Back-to-back, cmd_valid held with write 16'h0001 then read:
  - -> exactly one ncs-high cycle between transactions; second SETUP starts 11 cycles after the first accept edge; each command accepted once.
- Reset at cycle 5 of a read:
  - -> next edge gives ncs=noe=1, bus_oe=0, done never pulses, rdata stays 0; the first command after rst falls runs full timing.
- Parameter sweep ADDSET=1, DATAST=1, HOLD=1 and ADDSET=15, DATAST=15, HOLD=15:
  - -> ncs low for 3 and 45 cycles; strobe low for 1 and 15 cycles; protocol assertions (no dual strobe, no strobe without ncs) hold.
- Loopback against the FSMC responder (DATAST=6):
  - -> write addr 2'b10 index=0, write three words 16'h0011/16'h0022/16'h0033 to addr 2'b00, rewrite index=0, three reads -> rdata matches the responder's prefetch pipeline ordering.
